coords_reader: RTL and testbench
================================

Name: coords_reader

Overview:
- Sequencer that walks the 16-entry coordinates ROM from address 0 upward.
- Absorbs the ROM's synchronous read latency and streams each 36-bit entry, tagged with its index, to game logic over a valid/ready handshake.
- Terminates on the first all-zero entry (end-of-table marker) or after the last address.
- Sits between the ROM instance and the target-placement logic.

Parameters:
- ADDR_W, 4, ROM address width; table depth is 2^ADDR_W.
- DATA_W, 36, ROM word width.
- READ_LAT, 1, cycles from ce/address to valid rom_dout. Legal values: 1 (output register bypassed) or 2 (oce register used).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a table walk when idle.
- busy  output  1  high from the start acceptance cycle until done.
- done  output  1  one-cycle pulse after the final entry has been accepted downstream.
- entry_count  output  ADDR_W+1  number of entries delivered in the last walk; held until next start.
- rom_ad  output  ADDR_W  ROM address.
- rom_ce  output  1  ROM read enable.
- rom_oce  output  1  ROM output-register enable; constant 1.
- rom_reset  output  1  equals reset.
- rom_dout  input  DATA_W  ROM read data.
- m_valid  output  1  entry available.
- m_ready  input  1  downstream accepts when m_valid & m_ready.
- m_data  output  DATA_W  entry word.
- m_index  output  ADDR_W  ROM address of m_data.

Behaviour:
- Reset values: busy=0, done=0, entry_count=0, rom_ad=0, rom_ce=0, m_valid=0, m_data=0, m_index=0.
  - All in-flight reads and buffered entries are discarded.
  - Reset mid-walk aborts with no done pulse.
- States:
  - IDLE: start → FETCH; issue pointer=0, count=0, busy=1.
  - FETCH: issue reads and collect returns; on termination → DRAIN.
  - DRAIN: stop issuing; discard returns still in flight; → IDLE when the buffer is empty. Pulse done and latch entry_count on that transition.
  - start in FETCH or DRAIN is ignored.
- Issue rule: rom_ce=1 in a cycle when issue pointer ≤ 2^ADDR_W-1, no terminator has been seen, and (buffer occupancy + reads in flight) < READ_LAT+1. rom_ad = issue pointer, which then increments.
- Return tracking: a READ_LAT-deep shift register carries {valid, addr} for each issued read. The return is sampled on rom_dout when it exits the shift register.
- A returned word equal to 0 is the terminator:
  - it is not pushed;
  - it sets the terminator flag;
  - any later returns are dropped;
  - the state moves to DRAIN.
- A returned nonzero word is pushed as {data, addr} into an output FIFO of depth READ_LAT+1. Overflow is impossible by the issue rule.
- The walk also terminates (→ DRAIN) once the return for address 2^ADDR_W-1 has been processed with no zero seen.
- Output: m_valid = FIFO non-empty; m_data/m_index = FIFO head.
  - Head and m_valid are stable while m_valid & !m_ready.
  - Pop on m_valid & m_ready; count increments per pop.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- Throughput: with m_ready held high, one entry per clock after an initial latency of READ_LAT+1 cycles from start to first m_valid.
- Entries are delivered in strictly increasing address order with no gaps before the terminator.
- An entry whose only nonzero bits are in the padding is still nonzero and is delivered.
- done is asserted only when count equals the number of pushed entries and the FIFO is empty.

Test Plan:
- ROM model with nonzero entries at 0..14 and zero at 15, READ_LAT=1, m_ready=1, start → m_index 0..14 on consecutive cycles, data matching the model, single done, entry_count=15, busy then 0.
- Same table, READ_LAT=2 → identical sequence; first m_valid 3 cycles after start; no duplicate or skipped index.
- All 16 entries nonzero → 16 entries delivered, done, entry_count=16; no read issued past address 15.
- Entry 3 zero, entries 4..15 nonzero → only indices 0,1,2 delivered; entry_count=3; speculative returns from 4 onward dropped.
- m_ready random ~30% duty → m_data/m_index never change while m_valid & !m_ready; full ordered sequence delivered; buffer never exceeds READ_LAT+1.
- Reset asserted for 1 cycle while entry 5 is pending → all outputs at reset values next cycle, no done; a following start restarts at index 0. A start pulsed during busy is ignored.

Source files
------------

// File: rtl/coords_reader.sv
// Walks the coordinates ROM from address 0, hides its read latency and
// streams each nonzero entry with its index until the zero end marker.
module coords_reader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 36,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   entry_count,
    output logic [ADDR_W-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index
);

    localparam int DEPTH = READ_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LI    = READ_LAT - 1;
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t state, state_nx;

    logic [ADDR_W:0]   ptr;
    logic [ADDR_W:0]   count;
    logic              pipe_v [READ_LAT];
    logic [ADDR_W-1:0] pipe_a [READ_LAT];
    logic [DATA_W-1:0] fifo_d [DEPTH];
    logic [ADDR_W-1:0] fifo_a [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    logic ret_v, ret_zero, push, pop, stop, drained;
    int   inflight, claims;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rom_oce   = 1'b1;
    assign rom_reset = reset;
    assign busy      = (state != IDLE);
    assign m_valid   = (fifo_cnt != '0);
    assign m_data    = m_valid ? fifo_d[rd_ptr] : '0;
    assign m_index   = m_valid ? fifo_a[rd_ptr] : '0;
    assign rom_ad    = (state == FETCH) ? ptr[ADDR_W-1:0] : '0;

    // Returns only count while still fetching; later ones are speculative.
    assign ret_v    = pipe_v[LI] && (state == FETCH);
    assign ret_zero = (rom_dout == '0);
    assign push     = ret_v && !ret_zero;
    assign pop      = m_valid && m_ready;
    assign stop     = ret_v && (ret_zero || pipe_a[LI] == LAST[ADDR_W-1:0]);
    assign drained  = (state == DRAIN) && (fifo_cnt == '0);

    // Reserve a FIFO slot for every read before issuing it.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + int'(pipe_v[i]);
        end
        claims = int'(fifo_cnt) - int'(pop) + inflight;
    end

    always_comb begin
        state_nx = state;
        rom_ce   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    rom_ce   = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                rom_ce = (ptr <= LAST) && !stop && (claims < DEPTH);
                if (stop) state_nx = DRAIN;
            end
            DRAIN: begin
                if (fifo_cnt == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            count       <= '0;
            entry_count <= '0;
            done        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_v[i] <= 1'b0;
            end
        end else begin
            state <= state_nx;
            done  <= drained;
            if (rom_ce) begin
                ptr <= (state == IDLE) ? (ADDR_W+1)'(1) : ptr + 1'b1;
            end
            if (state == IDLE && start) count <= '0;
            else if (pop)               count <= count + 1'b1;
            if (drained) entry_count <= count;
            // Stale reads left over from the last walk die in IDLE.
            pipe_v[0] <= rom_ce;
            pipe_a[0] <= rom_ad;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= (state == IDLE) ? 1'b0 : pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            if (push) begin
                fifo_d[wr_ptr] <= rom_dout;
                fifo_a[wr_ptr] <= pipe_a[LI];
                wr_ptr         <= wrap_inc(wr_ptr);
            end
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_coords_reader.sv
// Bench for coords_reader: two instances (read latency 1 and 2) walk the
// same table against a behavioural ROM and an ordered-sequence model.
module tb_coords_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [35:0] mem [16];

    logic        bz  [2];
    logic        dn  [2];
    logic [4:0]  ec  [2];
    logic [3:0]  ad  [2];
    logic        ce  [2];
    logic        oce [2];
    logic        rr  [2];
    logic        mv  [2];
    logic        rdy [2];
    logic [35:0] md  [2];
    logic [3:0]  mi  [2];
    logic [35:0] rq  [2];
    logic [35:0] oq;

    int lat [2] = '{1, 2};
    int vectors = 0;
    int misc = 0;

    coords_reader #(.ADDR_W(4), .DATA_W(36), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .start(start),
        .busy(bz[0]), .done(dn[0]), .entry_count(ec[0]),
        .rom_ad(ad[0]), .rom_ce(ce[0]), .rom_oce(oce[0]),
        .rom_reset(rr[0]), .rom_dout(rq[0]),
        .m_valid(mv[0]), .m_ready(rdy[0]),
        .m_data(md[0]), .m_index(mi[0])
    );

    coords_reader #(.ADDR_W(4), .DATA_W(36), .READ_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .start(start),
        .busy(bz[1]), .done(dn[1]), .entry_count(ec[1]),
        .rom_ad(ad[1]), .rom_ce(ce[1]), .rom_oce(oce[1]),
        .rom_reset(rr[1]), .rom_dout(oq),
        .m_valid(mv[1]), .m_ready(rdy[1]),
        .m_data(md[1]), .m_index(mi[1])
    );

    // ROM: one register for latency 1, plus the output register for 2.
    always @(posedge clk) begin
        if (ce[0]) rq[0] <= mem[ad[0]];
        if (ce[1]) rq[1] <= mem[ad[1]];
        oq <= rq[1];
    end

    function automatic logic [35:0] rand_nz();
        logic [35:0] v;
        do v = {$urandom(), $urandom()}; while (v == '0);
        return v;
    endfunction

    function automatic int table_len();
        int n = 0;
        while (n < 16 && mem[n] != '0) n++;
        return n;
    endfunction

    task automatic run_walk(input string name, input bit always_rdy,
                            input bit poke);
        int exp_len;
        int got [2];
        int dones [2];
        int first [2];
        int fin;
        bit held [2];
        logic [35:0] hd [2];
        logic [3:0] hi [2];
        bit r;
        exp_len = table_len();
        fin = -1;
        for (int d = 0; d < 2; d++) begin
            got[d] = 0; dones[d] = 0; first[d] = -1; held[d] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        rdy[0] = always_rdy;
        rdy[1] = always_rdy;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 5);
            for (int d = 0; d < 2; d++) begin
                r = always_rdy ? 1'b1 : ($urandom_range(0, 99) < 30);
                rdy[d] = r;
                if (held[d]) begin
                    vectors++;
                    if (!mv[d] || md[d] !== hd[d] || mi[d] !== hi[d]) begin
                        misc++;
                        $display("FAIL %s hold dut%0d v=%0b idx=%0d/%0d",
                                 name, d, mv[d], mi[d], hi[d]);
                    end
                end
                if (mv[d] && first[d] < 0) begin
                    first[d] = cyc;
                    if (always_rdy) begin
                        vectors++;
                        if (cyc != lat[d] + 1) begin
                            misc++;
                            $display("FAIL %s latency dut%0d got %0d exp %0d",
                                     name, d, cyc, lat[d] + 1);
                        end
                    end
                end
                if (always_rdy && first[d] >= 0 && got[d] < exp_len) begin
                    vectors++;
                    if (!mv[d]) begin
                        misc++;
                        $display("FAIL %s gap dut%0d at entry %0d",
                                 name, d, got[d]);
                    end
                end
                if (mv[d] && r) begin
                    vectors++;
                    if (got[d] >= exp_len) begin
                        misc++;
                        $display("FAIL %s extra dut%0d idx %0d exp_len %0d",
                                 name, d, mi[d], exp_len);
                    end else if (mi[d] !== 4'(got[d]) ||
                                 md[d] !== mem[got[d]]) begin
                        misc++;
                        $display("FAIL %s entry dut%0d idx %0d exp %0d data %h exp %h",
                                 name, d, mi[d], got[d], md[d], mem[got[d]]);
                    end
                    got[d]++;
                end
                held[d] = mv[d] && !r;
                hd[d] = md[d];
                hi[d] = mi[d];
                if (dn[d]) begin
                    dones[d]++;
                    vectors++;
                    if (got[d] != exp_len || ec[d] !== 5'(exp_len) || bz[d]) begin
                        misc++;
                        $display("FAIL %s done dut%0d got %0d cnt %0d busy %0b exp %0d",
                                 name, d, got[d], ec[d], bz[d], exp_len);
                    end
                end
            end
            if (fin < 0 && dones[0] > 0 && dones[1] > 0) fin = cyc;
            if (fin >= 0 && cyc > fin + 3) break;
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (dones[d] != 1 || got[d] != exp_len || bz[d]) begin
                misc++;
                $display("FAIL %s end dut%0d dones %0d got %0d exp %0d busy %0b",
                         name, d, dones[d], got[d], exp_len, bz[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (bz[d] || dn[d] || ec[d] !== 5'd0 || ad[d] !== 4'd0 ||
                ce[d] || mv[d] || md[d] !== 36'd0 || mi[d] !== 4'd0 ||
                rr[d] !== 1'b1 || oce[d] !== 1'b1) begin
                misc++;
                $display("FAIL reset dut%0d busy %0b done %0b cnt %0d ce %0b v %0b rr %0b",
                         d, bz[d], dn[d], ec[d], ce[d], mv[d], rr[d]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (rr[d] !== 1'b0 || bz[d] || mv[d]) begin
                misc++;
                $display("FAIL reset_release dut%0d rr %0b busy %0b", d, rr[d], bz[d]);
            end
        end
    endtask

    task automatic test_end_marker();
        for (int i = 0; i < 15; i++) mem[i] = rand_nz();
        mem[15] = '0;
        run_walk("end_marker", 1'b1, 1'b0);
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 16; i++) mem[i] = rand_nz();
        mem[7] = 36'h8_0000_0000;
        run_walk("full_table", 1'b1, 1'b0);
    endtask

    task automatic test_early_zero();
        for (int i = 0; i < 16; i++) mem[i] = rand_nz();
        mem[3] = '0;
        run_walk("early_zero", 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int zpos;
        for (int k = 0; k < 6; k++) begin
            zpos = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) mem[i] = (i == zpos) ? '0 : rand_nz();
            run_walk("random_ready", 1'b0, (k % 2) == 1);
        end
    endtask

    task automatic test_abort();
        bit at5 [2];
        bit ok;
        for (int i = 0; i < 16; i++) mem[i] = rand_nz();
        @(negedge clk);
        start = 1'b1;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        ok = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            for (int d = 0; d < 2; d++) begin
                at5[d] = mv[d] && mi[d] == 4'd5;
                rdy[d] = !at5[d];
            end
            if (at5[0] && at5[1]) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            misc++;
            $display("FAIL abort_reach idx %0d/%0d", mi[0], mi[1]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (bz[d] || dn[d] || ec[d] !== 5'd0 || ad[d] !== 4'd0 ||
                ce[d] || mv[d] || md[d] !== 36'd0 || mi[d] !== 4'd0) begin
                misc++;
                $display("FAIL abort_reset dut%0d busy %0b done %0b cnt %0d v %0b idx %0d",
                         d, bz[d], dn[d], ec[d], mv[d], mi[d]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (dn[d] || mv[d] || bz[d]) begin
                    misc++;
                    $display("FAIL abort_quiet dut%0d done %0b v %0b busy %0b",
                             d, dn[d], mv[d], bz[d]);
                end
            end
        end
        run_walk("restart", 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_end_marker();
        test_full_table();
        test_early_zero();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
